vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Produces the raster-scan coordinate and sync stream that all pattern generators consume: x, y, display_on, next_frame, plus hsync/vsync for the VGA pins.
- Sits at top level between the clock/reset source and the pattern mux; every pattern block reads its x/y/next_frame.
- Default timing is 640x480 @ 60 Hz (800x525 total), advancing one pixel per pix_tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_tick  in  1  pixel-advance strobe, one clk wide (tie high when clk is the pixel clock)
- x  out  10  current column, 0..H_TOTAL-1
- y  out  10  current row, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  high while x<H_ACTIVE and y<V_ACTIVE
- next_frame  out  1  one-clk pulse at entry to vertical blank
- frame_count  out  16  frames completed (only with VGA_FRAME_COUNT_EN)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must fit in 10 bits.
- Reset (rst sampled high on a clk edge): x=0, y=0, hsync=1, vsync=1, display_on=1, next_frame=0, frame_count=0. Reset overrides pix_tick.
- Reset mid-frame returns to (0,0) on the next edge with no partial pulse.
- All outputs are registered and update on the same clk edge; there is no skew between x/y and the sync/enable flags.
- pix_tick low: x, y, hsync, vsync and display_on hold. next_frame is driven 0.
- pix_tick high:
  - x = x+1; at x==H_TOTAL-1, x wraps to 0 and y advances.
  - y = y+1 on each x wrap; at y==V_TOTAL-1 (with x at wrap), y wraps to 0.
- Flags below are computed from the post-update (next) x/y values:
  - hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491. vsync depends on y only, so it changes only at line boundaries.
  - display_on = (x<H_ACTIVE) && (y<V_ACTIVE).
- next_frame is 1 for exactly one clk: the edge on which the counters move to (x=0, y=V_ACTIVE), i.e. from (799,479) to (0,480). It therefore occurs once per frame, in blanking, so pattern state updates never tear the visible image.
- Comparisons are unsigned 10-bit.
- Frame period = 420000 pix_ticks.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: adds the frame_count port, a 16-bit counter that increments on the same edge next_frame pulses and wraps 65535->0. Reset value 0.
- Undefined: no frame_count port and no counter logic; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants
  - derived H_TOTAL/V_TOTAL and the sync start/end constants
  - the 10-bit coordinate width constant
  - a coord_t typedef (10-bit)
- Sub-module vga_axis_counter is instantiated twice (horizontal and vertical):
  - inputs: clk, rst, inc, ACTIVE/FP/SYNC/BP parameters
  - outputs: count, wrap (combinational, inc && count==TOTAL-1), active, sync_n
  - The horizontal instance's inc is pix_tick; the vertical instance's inc is the horizontal wrap.

Test Plan:
- Reset: hold rst 3 clks with pix_tick=1 -> x=0, y=0, hsync=1, vsync=1, display_on=1, next_frame=0. Release -> x=1 after the first edge.
- Horizontal line, pix_tick=1 continuously:
  - x counts 0..799 then returns to 0 with y=1.
  - hsync low for exactly 96 clks starting at x=656.
  - display_on low from x=640.
- Full frame:
  - next_frame pulses once, on the edge producing (0,480).
  - Next pulse is exactly 420000 clks later.
  - vsync low for 1600 clks covering y=490..491.
  - display_on count = 307200 per frame.
- pix_tick gating: pix_tick=1 every 2nd clk -> frame period 840000 clks; outputs frozen on idle clks; next_frame stays a single-clk pulse.
- Mid-frame reset: run to (400,300), assert rst 1 clk -> (0,0) next edge, no next_frame, and the next pulse arrives 480*800 ticks later.
- With VGA_FRAME_COUNT_EN: run 3 frames -> frame_count=3. Preload near wrap via forced simulation -> 65535 increments to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA timing generator.
// Defaults describe 640x480 @ 60 Hz (800x525 total).
package vga_timing_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_DEF      = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL_DEF      = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active and sync flags.
// Flags are derived from the post-increment count so they never lag the count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   inc,
   output coord_t count,
   output logic   wrap,
   output logic   active,
   output logic   sync_n
);

   localparam int     TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam coord_t LAST       = coord_t'(TOTAL - 1);
   localparam coord_t ACT_END    = coord_t'(ACTIVE);
   localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
   localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

   coord_t count_q, count_d;
   logic   active_q, active_d;
   logic   sync_n_q, sync_n_d;

   assign wrap = inc && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
      active_d = (count_d < ACT_END);
      sync_n_d = !((count_d >= SYNC_START) && (count_d < SYNC_END));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         active_q <= 1'b1;
         sync_n_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         active_q <= active_d;
         sync_n_q <= sync_n_d;
      end
   end

   assign count  = count_q;
   assign active = active_q;
   assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y coordinates, hsync/vsync, display_on and next_frame.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_tick,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               next_frame
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [15:0]        frame_count
`endif
);

   localparam coord_t V_LAST_ACTIVE = coord_t'(V_ACTIVE - 1);

   coord_t h_count, v_count;
   logic   h_wrap, v_wrap;
   logic   h_active, v_active;
   logic   h_sync_n, v_sync_n;
   logic   next_frame_q, next_frame_d;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk    (clk),
      .rst    (rst),
      .inc    (pix_tick),
      .count  (h_count),
      .wrap   (h_wrap),
      .active (h_active),
      .sync_n (h_sync_n)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk    (clk),
      .rst    (rst),
      .inc    (h_wrap),
      .count  (v_count),
      .wrap   (v_wrap),
      .active (v_active),
      .sync_n (v_sync_n)
   );

   // The frame wrap itself is not needed; vertical blank entry is what patterns key on.
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

   assign next_frame_d = h_wrap && (v_count == V_LAST_ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         next_frame_q <= 1'b0;
      end else begin
         next_frame_q <= next_frame_d;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_count_q, frame_count_d;

   assign frame_count_d = frame_count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_q <= '0;
      end else if (next_frame_d) begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

   // Both active flags are flops clocked on the same edge, so display_on tracks x/y exactly.
   assign x          = h_count;
   assign y          = v_count;
   assign hsync      = h_sync_n;
   assign vsync      = v_sync_n;
   assign display_on = h_active && v_active;
   assign next_frame = next_frame_q;

endmodule
